// File: rtl/wb_port_arbiter.sv
// Write-back arbiter for the integer register file: round-robin between the ALU and load
// paths onto the single write port, plus a busy scoreboard that drives the decode stall.
module wb_port_arbiter #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int REG_DATA_WIDTH = 64,
  parameter int REG_COUNT      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_DATA_WIDTH-1:0] alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  input  logic [REG_DATA_WIDTH-1:0] mem_data,
  output logic                      mem_ready,
  input  logic                      issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      hazard,
  output logic                      RegWrite,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
  output logic [REG_DATA_WIDTH-1:0] write_reg_data
);

  localparam logic GRANT_ALU = 1'b0;
  localparam logic GRANT_MEM = 1'b1;

  logic                      last_grant;
  logic                      xfer_p0;
  logic [REG_ADDR_WIDTH-1:0] rd_p0;
  logic [REG_DATA_WIDTH-1:0] data_p0;
  logic [REG_COUNT-1:0]      busy;
  logic [REG_COUNT-1:0]      busy_next;

  // Scoreboard lookup; x0 and indices beyond REG_COUNT never report busy.
  function automatic logic busy_at(input logic [REG_COUNT-1:0] bits,
                                   input logic [REG_ADDR_WIDTH-1:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (addr == REG_ADDR_WIDTH'(i)) hit = bits[i];
    end
    return hit;
  endfunction

  // Stage p0: arbitration. On a tie the requester not granted most recently wins.
  always_comb begin
    alu_ready = alu_valid && (!mem_valid || (last_grant == GRANT_MEM));
    mem_ready = mem_valid && (!alu_valid || (last_grant == GRANT_ALU));
    xfer_p0   = alu_ready || mem_ready;
    rd_p0     = alu_ready ? alu_rd   : mem_rd;
    data_p0   = alu_ready ? alu_data : mem_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_MEM;
    end else if (xfer_p0) begin
      last_grant <= alu_ready ? GRANT_ALU : GRANT_MEM;
    end
  end

  // Stage p1: registered write port. A transfer to x0 handshakes but never writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RegWrite       <= 1'b0;
      write_reg_addr <= '0;
      write_reg_data <= '0;
    end else begin
      RegWrite <= xfer_p0 && (rd_p0 != '0);
      if (xfer_p0) begin
        write_reg_addr <= rd_p0;
        write_reg_data <= data_p0;
      end
    end
  end

  // Clear on commit first, then apply the new issue so a newer in-flight writer wins.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (RegWrite && (write_reg_addr == REG_ADDR_WIDTH'(i))) busy_next[i] = 1'b0;
      if (issue_valid && (issue_rd == REG_ADDR_WIDTH'(i)))    busy_next[i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign hazard = busy_at(busy, rs1_addr) || busy_at(busy, rs2_addr);

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back arbiter and scoreboard for the single-cycle/pipelined RISC-V core's 32×64-bit integer register file. It shares the register file's single write port between two requesters, the ALU result path and the memory-load path. Arbitration is round-robin with valid/ready handshakes. The block also keeps a per-register busy scoreboard so decode can stall on reads of registers whose write-back is still outstanding. It sits between EX/MEM and the ID-stage register file and drives the file's `RegWrite`, `write_reg_addr` and `write_reg_data` inputs.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, default 5: register index width.
- `REG_DATA_WIDTH`, default 64: register data width.
- `REG_COUNT`, default 32: number of architectural registers. Scoreboard depth.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset, asynchronous, active-high.
- `alu_valid`, in, 1: ALU write-back request.
- `alu_rd`, in, REG_ADDR_WIDTH: ALU destination register.
- `alu_data`, in, REG_DATA_WIDTH: ALU result.
- `alu_ready`, out, 1: ALU request accepted this cycle. Combinational.
- `mem_valid`, in, 1: load write-back request.
- `mem_rd`, in, REG_ADDR_WIDTH: load destination register.
- `mem_data`, in, REG_DATA_WIDTH: load data.
- `mem_ready`, out, 1: load request accepted this cycle. Combinational.
- `issue_valid`, in, 1: an instruction with a destination register is issued.
- `issue_rd`, in, REG_ADDR_WIDTH: destination of the issued instruction.
- `rs1_addr`, in, REG_ADDR_WIDTH: decode source register 1.
- `rs2_addr`, in, REG_ADDR_WIDTH: decode source register 2.
- `hazard`, out, 1: rs1 or rs2 is busy. Combinational.
- `RegWrite`, out, 1: register-file write enable. Registered.
- `write_reg_addr`, out, REG_ADDR_WIDTH: register-file write address. Registered.
- `write_reg_data`, out, REG_DATA_WIDTH: register-file write data. Registered.

## Operation
Arbitration:
- A transfer occurs on a requester when its valid and ready are both high at a rising edge.
- At most one transfer happens per cycle.
- Only ALU valid: `alu_ready` = 1.
- Only MEM valid: `mem_ready` = 1.
- Both valid: grant the requester not granted most recently.
- Ready is never asserted without the matching valid.

Round-robin state:
- `last_grant` is 1 bit: 0 = ALU, 1 = MEM.
- It updates only on a transfer.
- Reset value is MEM, so the ALU wins the first tie.

Output stage:
- The accepted rd and data are registered into `write_reg_addr` and `write_reg_data`.
- `RegWrite` is registered as 1 if a transfer occurred and rd ≠ 0, else 0.
- A requester targeting x0 still handshakes, but no write is issued and the scoreboard is untouched.

Scoreboard:
- `busy[REG_COUNT-1:0]`.
- Set: `issue_valid` with `issue_rd` ≠ 0 sets `busy[issue_rd]` at the edge.
- Clear: a cycle with `RegWrite` = 1 clears `busy[write_reg_addr]` at the end of that cycle, which is the same edge the register file commits.
- Set and clear of the same index in the same cycle: set wins, because a newer writer is in flight.
- `hazard` = (`rs1_addr` ≠ 0 && `busy[rs1_addr]`) || (`rs2_addr` ≠ 0 && `busy[rs2_addr]`).
- `busy[0]` is always 0.
- The scoreboard tracks only whether a register has any outstanding writer. Multiple outstanding writes to one register are not counted.

Reset:
- `RegWrite`, `write_reg_addr` and `write_reg_data` = 0.
- All busy bits = 0.
- `last_grant` = MEM.
- Reset mid-operation discards any registered write in the output stage; no write reaches the register file.
- Ready and `hazard` follow their combinational equations from the cleared state.

## Timing
- Accept at edge N → `RegWrite`, address and data valid during cycle N+1 → register file written at edge N+1.
- Write-back latency is 1 cycle.
- Sustained throughput is 1 write per cycle.
- Two continuously valid requesters alternate grants: ALU, MEM, ALU, …
- A non-granted requester must hold valid, rd and data stable until its ready is seen high.
- Busy-bit lifetime:
  - `issue_valid` at edge I sets the bit; `hazard` is visible from cycle I+1.
  - The bit clears at edge N+1 for a write accepted at N.
  - `hazard` deasserts in cycle N+2, when the register file already holds the new value.
- The read path is combinational. The scoreboard adds no bypass; the stall covers the full write latency.

## Test plan
- Reset, then ALU only: alu_rd=5, data=0x1234 at edge 1 → `RegWrite`=1, addr=5, data=0x1234 in cycle 2; `mem_ready`=0 throughout.
- Both valid for 4 cycles (ALU rd=1, MEM rd=2) → grants ALU, MEM, ALU, MEM; `write_reg_addr` sequence 1, 2, 1, 2; each ready held low while the other is granted.
- x0 target: mem_rd=0, data=0xFFFF → `mem_ready`=1, `RegWrite`=0 next cycle; `busy` unchanged.
- Scoreboard: issue rd=7, then rs1_addr=7 → `hazard`=1; ALU writes rd=7 → `hazard`=0 two cycles after accept. rs2_addr=0 never asserts `hazard`.
- Same-cycle set and clear on rd=3 (commit and new issue) → `busy[3]` stays 1 and `hazard` stays 1 for rs1=3.
- Assert reset while an accepted write is in the output stage → `RegWrite`=0 immediately; all busy bits 0; the first tie after release goes to ALU.
